// File: rtl/pipe_lmsm_ctrl.sv
// Pipeline sequencing controller: stage load/hold, PC enable, load-use stall,
// branch flush and LM/SM expansion into one micro-op per listed register.
module pipe_lmsm_ctrl #(
    parameter int unsigned NSTAGE  = 5,
    parameter int unsigned RLIST_W = 8,
    parameter int unsigned RADDR_W = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               id_is_lmsm,
    input  logic               id_is_lm,
    input  logic [RLIST_W-1:0] id_rlist,
    input  logic               loaduse_hazard,
    input  logic               branch_taken,
    output logic [NSTAGE-1:0]  stage_ld,
    output logic [NSTAGE-1:0]  stage_hold,
    output logic               pc_we,
    output logic               seq_active,
    output logic               seq_is_lm,
    output logic [RADDR_W-1:0] seq_reg_addr,
    output logic [RADDR_W-1:0] seq_offset,
    output logic               seq_last
);

    typedef enum logic [1:0] {IDLE, SETUP, SEQ} state_t;

    state_t               state, state_nxt;
    logic [RLIST_W-1:0]   rlist_q, rlist_nxt;
    logic [RADDR_W-1:0]   offset_q, offset_nxt;
    logic                 is_lm_q, is_lm_nxt;

    logic [NSTAGE-1:0]    ld_c, hold_c;
    logic                 pc_we_c, active_c, last_c;
    logic [RADDR_W-1:0]   addr_c, off_c;
    logic [RADDR_W-1:0]   low_idx;
    logic [RLIST_W-1:0]   rlist_rest;
    logic                 single;

    // Index of the lowest set bit; scanning downward lets the lowest hit win.
    always_comb begin
        low_idx = '0;
        for (int i = int'(RLIST_W) - 1; i >= 0; i--) begin
            if (rlist_q[i]) low_idx = RADDR_W'(i);
        end
    end

    assign rlist_rest = rlist_q & (rlist_q - RLIST_W'(1));
    assign single     = (rlist_q != '0) && (rlist_rest == '0);

    // State, latched register list, micro-op offset and LM/SM type.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            rlist_q  <= '0;
            offset_q <= '0;
            is_lm_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rlist_q  <= rlist_nxt;
            offset_q <= offset_nxt;
            is_lm_q  <= is_lm_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rlist_nxt  = rlist_q;
        offset_nxt = offset_q;
        is_lm_nxt  = is_lm_q;
        ld_c       = '1;
        hold_c     = '0;
        pc_we_c    = 1'b1;
        active_c   = 1'b0;
        last_c     = 1'b0;
        addr_c     = '0;
        off_c      = '0;

        if (branch_taken) begin
            ld_c[2:0]  = 3'b000;
            state_nxt  = IDLE;
            rlist_nxt  = '0;
            offset_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (loaduse_hazard) begin
                        pc_we_c     = 1'b0;
                        hold_c[1:0] = 2'b11;
                        ld_c[2]     = 1'b0;
                    end else if (id_is_lmsm && (id_rlist != '0)) begin
                        pc_we_c    = 1'b0;
                        hold_c[0]  = 1'b1;
                        ld_c[1]    = 1'b0;
                        rlist_nxt  = id_rlist;
                        is_lm_nxt  = id_is_lm;
                        offset_nxt = '0;
                        state_nxt  = SETUP;
                    end
                end
                SETUP: begin
                    pc_we_c   = 1'b0;
                    hold_c[0] = 1'b1;
                    if (loaduse_hazard) begin
                        hold_c[1] = 1'b1;
                        ld_c[2]   = 1'b0;
                    end else begin
                        ld_c[1]   = 1'b0;
                        state_nxt = SEQ;
                    end
                end
                SEQ: begin
                    pc_we_c   = 1'b0;
                    hold_c[0] = 1'b1;
                    addr_c    = low_idx;
                    off_c     = offset_q;
                    if (loaduse_hazard) begin
                        hold_c[1] = 1'b1;
                        ld_c[2]   = 1'b0;
                    end else begin
                        active_c   = 1'b1;
                        last_c     = single;
                        rlist_nxt  = rlist_rest;
                        offset_nxt = offset_q + RADDR_W'(1);
                        if (single) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Everything is forced low while reset is asserted, independent of the clock.
    assign stage_ld     = resetn ? ld_c     : '0;
    assign stage_hold   = resetn ? hold_c   : '0;
    assign pc_we        = resetn & pc_we_c;
    assign seq_active   = resetn & active_c;
    assign seq_is_lm    = resetn & is_lm_q;
    assign seq_reg_addr = resetn ? addr_c   : '0;
    assign seq_offset   = resetn ? off_c    : '0;
    assign seq_last     = resetn & last_c;

endmodule

// File: tb/tb_pipe_lmsm_ctrl.sv
// Directed bench for pipe_lmsm_ctrl: stall, LM/SM expansion, flush and reset.
module tb_pipe_lmsm_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       id_is_lmsm, id_is_lm, loaduse_hazard, branch_taken;
    logic [7:0] id_rlist;
    logic [4:0] stage_ld, stage_hold;
    logic       pc_we, seq_active, seq_is_lm, seq_last;
    logic [2:0] seq_reg_addr, seq_offset;

    int n_checks = 0;
    int n_errors = 0;
    int seq_cycles;

    pipe_lmsm_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .id_is_lmsm     (id_is_lmsm),
        .id_is_lm       (id_is_lm),
        .id_rlist       (id_rlist),
        .loaduse_hazard (loaduse_hazard),
        .branch_taken   (branch_taken),
        .stage_ld       (stage_ld),
        .stage_hold     (stage_hold),
        .pc_we          (pc_we),
        .seq_active     (seq_active),
        .seq_is_lm      (seq_is_lm),
        .seq_reg_addr   (seq_reg_addr),
        .seq_offset     (seq_offset),
        .seq_last       (seq_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_pipe(input string tag, input logic [4:0] ld, input logic [4:0] hold,
                            input logic pc, input logic act);
        chk({tag, ".ld"},   32'(stage_ld),   32'(ld));
        chk({tag, ".hold"}, 32'(stage_hold), 32'(hold));
        chk({tag, ".pc"},   32'(pc_we),      32'(pc));
        chk({tag, ".act"},  32'(seq_active), 32'(act));
    endtask

    task automatic chk_seq(input string tag, input logic [2:0] addr, input logic [2:0] off,
                           input logic last, input logic is_lm);
        chk_pipe(tag, 5'b11111, 5'b00001, 1'b0, 1'b1);
        chk({tag, ".addr"}, 32'(seq_reg_addr), 32'(addr));
        chk({tag, ".off"},  32'(seq_offset),   32'(off));
        chk({tag, ".last"}, 32'(seq_last),     32'(last));
        chk({tag, ".islm"}, 32'(seq_is_lm),    32'(is_lm));
    endtask

    // Advance to the next negedge; inputs change there and checks follow #1 later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic enter_lmsm(input logic lm, input logic [7:0] rl);
        next_cycle();
        id_is_lmsm = 1'b1; id_is_lm = lm; id_rlist = rl;
        #1 chk_pipe("entry", 5'b11101, 5'b00001, 1'b0, 1'b0);
        next_cycle();
        id_is_lmsm = 1'b0; id_is_lm = 1'b0; id_rlist = 8'h00;
        #1 chk_pipe("setup", 5'b11101, 5'b00001, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_pipe(tag, 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk({tag, ".seq"}, 32'({seq_is_lm, seq_reg_addr, seq_offset, seq_last}), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; id_is_lmsm = 1'b0; id_is_lm = 1'b0; id_rlist = 8'h00;
        loaduse_hazard = 1'b0; branch_taken = 1'b0;
        #1 chk_all_zero("rst");
        repeat (2) next_cycle();
        resetn = 1'b1;
        #1 chk_pipe("idle", 5'b11111, 5'b00000, 1'b1, 1'b0);

        // Single-cycle load-use stall in IDLE.
        next_cycle();
        loaduse_hazard = 1'b1;
        #1 chk_pipe("lu", 5'b11011, 5'b00011, 1'b0, 1'b0);
        next_cycle();
        loaduse_hazard = 1'b0;
        #1 chk_pipe("lu_after", 5'b11111, 5'b00000, 1'b1, 1'b0);

        // LM with three registers: 2, 5, 7.
        enter_lmsm(1'b1, 8'b1010_0100);
        next_cycle(); #1 chk_seq("lm_a4_0", 3'd2, 3'd0, 1'b0, 1'b1);
        next_cycle(); #1 chk_seq("lm_a4_1", 3'd5, 3'd1, 1'b0, 1'b1);
        next_cycle(); #1 chk_seq("lm_a4_2", 3'd7, 3'd2, 1'b1, 1'b1);
        next_cycle(); #1 chk_pipe("lm_a4_done", 5'b11111, 5'b00000, 1'b1, 1'b0);

        // SM with an empty list behaves as a normal instruction.
        next_cycle();
        id_is_lmsm = 1'b1; id_is_lm = 1'b0; id_rlist = 8'h00;
        #1 chk_pipe("sm_00", 5'b11111, 5'b00000, 1'b1, 1'b0);
        next_cycle();
        id_is_lmsm = 1'b0;
        #1 chk_pipe("sm_00_next", 5'b11111, 5'b00000, 1'b1, 1'b0);

        // SM 0x0F aborted by a branch in its second micro-op.
        enter_lmsm(1'b0, 8'h0F);
        next_cycle(); #1 chk_seq("sm_0f_0", 3'd0, 3'd0, 1'b0, 1'b0);
        next_cycle();
        branch_taken = 1'b1;
        #1 begin
            chk("br.ld",   32'(stage_ld),   32'(5'b11000));
            chk("br.hold", 32'(stage_hold), 32'(5'b00000));
            chk("br.pc",   32'(pc_we),      32'd1);
        end
        next_cycle();
        branch_taken = 1'b0;
        #1 chk_pipe("br_after", 5'b11111, 5'b00000, 1'b1, 1'b0);

        // LM 0x03 with a hazard on the first micro-op: reg 0 reissued.
        enter_lmsm(1'b1, 8'h03);
        seq_cycles = 0;
        next_cycle();
        loaduse_hazard = 1'b1;
        #1 chk_pipe("lm03_haz", 5'b11011, 5'b00011, 1'b0, 1'b0);
        seq_cycles++;
        next_cycle();
        loaduse_hazard = 1'b0;
        #1 chk_seq("lm03_0", 3'd0, 3'd0, 1'b0, 1'b1);
        seq_cycles++;
        next_cycle(); #1 chk_seq("lm03_1", 3'd1, 3'd1, 1'b1, 1'b1);
        seq_cycles++;
        next_cycle(); #1 chk_pipe("lm03_done", 5'b11111, 5'b00000, 1'b1, 1'b0);
        chk("lm03_seq_cycles", 32'(seq_cycles), 32'd3);

        // Top bit only: one micro-op at register 7.
        enter_lmsm(1'b0, 8'h80);
        next_cycle(); #1 chk_seq("sm_80", 3'd7, 3'd0, 1'b1, 1'b0);
        next_cycle(); #1 chk_pipe("sm_80_done", 5'b11111, 5'b00000, 1'b1, 1'b0);

        // Asynchronous reset mid-sequence, away from any clock edge.
        enter_lmsm(1'b1, 8'h0C);
        next_cycle(); #1 chk_seq("pre_rst", 3'd2, 3'd0, 1'b0, 1'b1);
        #2 resetn = 1'b0;
        #1 chk_all_zero("mid_rst");
        next_cycle();
        resetn = 1'b1;
        #1 begin
            chk_pipe("post_rst", 5'b11111, 5'b00000, 1'b1, 1'b0);
            chk("post_rst.islm", 32'(seq_is_lm), 32'd0);
        end

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
